// File: rtl/uart_regs_arbiter.sv
// uart_regs_arbiter: shares the UART register port between APB (req 0) and DMA (req 1); round-robin, or APB-first with UART_REGS_ARB_FIXED_PRIO_EN.
// Latency: strobe one cycle after the request is seen in IDLE, pready/dma_ack one cycle after that; one access per 3 cycles.
// Backpressure: APB is stalled with pready wait states, DMA holds dma_req until dma_ack; the losing request stays pending.
module uart_regs_arbiter #(
    parameter int ADDR_WD = 12
) (
    input  logic               pclk,
    input  logic               preset,
    input  logic               psel,
    input  logic               penable,
    input  logic               pwrite,
    input  logic [ADDR_WD-1:0] paddr,
    input  logic [31:0]        pwdata,
    output logic [31:0]        prdata,
    output logic               pready,
    input  logic               dma_req,
    input  logic               dma_we,
    input  logic [ADDR_WD-1:0] dma_addr,
    input  logic [31:0]        dma_wdata,
    output logic               dma_ack,
    output logic [31:0]        dma_rdata,
    output logic [ADDR_WD-1:0] reg_addr,
    output logic               reg_read_en,
    output logic               reg_write_en,
    output logic [31:0]        reg_wdata,
    input  logic [31:0]        reg_rdata
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_XFER,
        ST_DONE
    } state_t;

    state_t state;
    logic   cur_dma;
    logic   apb_req;
    logic   grant_dma;
    logic   win_we;
    logic [ADDR_WD-1:0] win_addr;
    logic [31:0]        win_wdata;

    assign apb_req = psel & penable;

`ifdef UART_REGS_ARB_FIXED_PRIO_EN
    assign grant_dma = dma_req & ~apb_req;
`else
    logic last_grant;
    // On a tie the requester that was not served last wins.
    assign grant_dma = dma_req & (~apb_req | ~last_grant);
`endif

    assign win_we    = grant_dma ? dma_we    : pwrite;
    assign win_addr  = grant_dma ? dma_addr  : paddr;
    assign win_wdata = grant_dma ? dma_wdata : pwdata;

    always_ff @(posedge pclk or posedge preset) begin
        if (preset) begin
            state        <= ST_IDLE;
            cur_dma      <= 1'b0;
            prdata       <= '0;
            dma_rdata    <= '0;
            pready       <= 1'b0;
            dma_ack      <= 1'b0;
            reg_read_en  <= 1'b0;
            reg_write_en <= 1'b0;
            reg_addr     <= '0;
            reg_wdata    <= '0;
`ifndef UART_REGS_ARB_FIXED_PRIO_EN
            last_grant   <= 1'b1;
`endif
        end else begin
            case (state)
                ST_IDLE: begin
                    if (apb_req | dma_req) begin
                        cur_dma      <= grant_dma;
                        reg_addr     <= win_addr;
                        reg_wdata    <= win_wdata;
                        reg_write_en <= win_we;
                        reg_read_en  <= ~win_we;
`ifndef UART_REGS_ARB_FIXED_PRIO_EN
                        last_grant   <= grant_dma;
`endif
                        state        <= ST_XFER;
                    end
                end
                ST_XFER: begin
                    reg_write_en <= 1'b0;
                    reg_read_en  <= 1'b0;
                    if (reg_read_en) begin
                        if (cur_dma) begin
                            dma_rdata <= reg_rdata;
                        end else begin
                            prdata <= reg_rdata;
                        end
                    end
                    pready  <= ~cur_dma;
                    dma_ack <= cur_dma;
                    state   <= ST_DONE;
                end
                ST_DONE: begin
                    pready  <= 1'b0;
                    dma_ack <= 1'b0;
                    state   <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_regs_arbiter.sv
// Bench for uart_regs_arbiter: directed scenarios plus random APB/DMA traffic against a slot-timing model.
module tb_uart_regs_arbiter;
    localparam int AW = 12;
`ifdef UART_REGS_ARB_FIXED_PRIO_EN
    localparam bit FIXED = 1'b1;
`else
    localparam bit FIXED = 1'b0;
`endif

    logic          pclk = 1'b0;
    logic          preset = 1'b1;
    logic          psel = 1'b0, penable = 1'b0, pwrite = 1'b0;
    logic [AW-1:0] paddr = '0;
    logic [31:0]   pwdata = '0;
    logic [31:0]   prdata;
    logic          pready;
    logic          dma_req = 1'b0, dma_we = 1'b0;
    logic [AW-1:0] dma_addr = '0;
    logic [31:0]   dma_wdata = '0;
    logic          dma_ack;
    logic [31:0]   dma_rdata;
    logic [AW-1:0] reg_addr;
    logic          reg_read_en, reg_write_en;
    logic [31:0]   reg_wdata;
    logic [31:0]   reg_rdata;

    logic [31:0] mem [0:4095];
    assign reg_rdata = mem[reg_addr];

    uart_regs_arbiter #(.ADDR_WD(AW)) dut (
        .pclk(pclk), .preset(preset),
        .psel(psel), .penable(penable), .pwrite(pwrite), .paddr(paddr), .pwdata(pwdata),
        .prdata(prdata), .pready(pready),
        .dma_req(dma_req), .dma_we(dma_we), .dma_addr(dma_addr), .dma_wdata(dma_wdata),
        .dma_ack(dma_ack), .dma_rdata(dma_rdata),
        .reg_addr(reg_addr), .reg_read_en(reg_read_en), .reg_write_en(reg_write_en),
        .reg_wdata(reg_wdata), .reg_rdata(reg_rdata)
    );

    always #5 pclk = ~pclk;

    int total = 0;
    int bad = 0;
    int cyc = 0;
    int n_strobe = 0;

    always @(posedge pclk) begin
        cyc <= cyc + 1;
        if (reg_write_en || reg_read_en) n_strobe <= n_strobe + 1;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic step();
        @(posedge pclk);
        #1;
    endtask

    // Model: an access granted in cycle c strobes at c+1, acks at c+2, and the next grant is possible at c+3.
    int            s_cyc = -100;
    bit            s_dma, s_we;
    logic [AW-1:0] s_addr;
    logic [31:0]   s_wdata, s_rd;
    int            nxt_idle = 0;
    bit            lg = 1'b1;
    logic [31:0]   m_prdata = '0, m_dmard = '0;

    always @(negedge pclk) begin
        if (preset) begin
            s_cyc = -100; nxt_idle = 0; lg = 1'b1; m_prdata = '0; m_dmard = '0;
            chk("rst_wen", 32'(reg_write_en), 32'd0);
            chk("rst_ren", 32'(reg_read_en), 32'd0);
            chk("rst_pready", 32'(pready), 32'd0);
            chk("rst_dma_ack", 32'(dma_ack), 32'd0);
            chk("rst_prdata", prdata, 32'd0);
            chk("rst_dma_rdata", dma_rdata, 32'd0);
            chk("rst_reg_addr", 32'(reg_addr), 32'd0);
            chk("rst_reg_wdata", reg_wdata, 32'd0);
        end else begin
            if (cyc == s_cyc + 1 && !s_we) begin
                if (s_dma) m_dmard = s_rd;
                else       m_prdata = s_rd;
            end
            chk("m_wen", 32'(reg_write_en), 32'(cyc == s_cyc && s_we));
            chk("m_ren", 32'(reg_read_en), 32'(cyc == s_cyc && !s_we));
            if (cyc == s_cyc) begin
                chk("m_reg_addr", 32'(reg_addr), 32'(s_addr));
                chk("m_reg_wdata", reg_wdata, s_wdata);
            end
            chk("m_pready", 32'(pready), 32'(cyc == s_cyc + 1 && !s_dma));
            chk("m_dma_ack", 32'(dma_ack), 32'(cyc == s_cyc + 1 && s_dma));
            chk("m_prdata", prdata, m_prdata);
            chk("m_dma_rdata", dma_rdata, m_dmard);
            if (cyc >= nxt_idle && ((psel && penable) || dma_req)) begin
                if ((psel && penable) && dma_req) s_dma = FIXED ? 1'b0 : !lg;
                else                              s_dma = dma_req;
                lg      = s_dma;
                s_we    = s_dma ? dma_we : pwrite;
                s_addr  = s_dma ? dma_addr : paddr;
                s_wdata = s_dma ? dma_wdata : pwdata;
                s_rd    = mem[s_addr];
                s_cyc   = cyc + 1;
                nxt_idle = cyc + 3;
            end
        end
    end

    initial begin
        #300000;
        bad++;
        $display("FAIL watchdog: simulation time limit reached");
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    localparam logic [AW-1:0] TIE2_FIRST  = FIXED ? 12'h050 : 12'h060;
    localparam logic [AW-1:0] TIE2_SECOND = FIXED ? 12'h060 : 12'h050;

    initial begin
        int s0;
        for (int i = 0; i < 4096; i++) mem[i] = $urandom;
        mem[12'h008] = 32'h1234_5678;
        mem[12'h020] = 32'hDEAD_BEEF;
        for (int k = 0; k < 4; k++) mem[12'h010 + 4 * k] = 32'hB000_0000 + k;

        repeat (3) step();
        preset = 1'b0;
        step();

        // Single APB write
        psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 12'h004; pwdata = 32'hA5A5_0001;
        chk("d_setup_pready", 32'(pready), 32'd0);
        step(); penable = 1'b1; s0 = n_strobe;
        step();
        chk("d_wr_wen", 32'(reg_write_en), 32'd1);
        chk("d_wr_addr", 32'(reg_addr), 32'h004);
        chk("d_wr_wdata", reg_wdata, 32'hA5A5_0001);
        chk("d_wr_pready_early", 32'(pready), 32'd0);
        step();
        chk("d_wr_pready", 32'(pready), 32'd1);
        psel = 1'b0; penable = 1'b0;
        step(); step();
        chk("d_wr_strobes", 32'(n_strobe - s0), 32'd1);

        // APB read, then a DMA read that must not disturb prdata
        psel = 1'b1; pwrite = 1'b0; paddr = 12'h008;
        step(); penable = 1'b1;
        step();
        chk("d_rd_ren", 32'(reg_read_en), 32'd1);
        step();
        chk("d_rd_pready", 32'(pready), 32'd1);
        chk("d_rd_prdata", prdata, 32'h1234_5678);
        psel = 1'b0; penable = 1'b0;
        step();
        dma_req = 1'b1; dma_we = 1'b0; dma_addr = 12'h020;
        step(); step();
        chk("d_dma_ack", 32'(dma_ack), 32'd1);
        chk("d_dma_rdata", dma_rdata, 32'hDEAD_BEEF);
        dma_req = 1'b0;
        step(); step();
        chk("d_prdata_hold", prdata, 32'h1234_5678);

        // Tie straight out of reset: APB first, DMA in the next slot
        preset = 1'b1; step(); step(); preset = 1'b0; step();
        psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 12'h030; pwdata = 32'h11;
        step();
        penable = 1'b1; dma_req = 1'b1; dma_we = 1'b1; dma_addr = 12'h040; dma_wdata = 32'h22;
        step();
        chk("d_tie1_addr", 32'(reg_addr), 32'h030);
        step();
        chk("d_tie1_pready", 32'(pready), 32'd1);
        chk("d_tie1_noack", 32'(dma_ack), 32'd0);
        psel = 1'b0; penable = 1'b0;
        step(); step();
        chk("d_tie1_dma_wen", 32'(reg_write_en), 32'd1);
        chk("d_tie1_dma_addr", 32'(reg_addr), 32'h040);
        chk("d_tie1_dma_wdata", reg_wdata, 32'h22);
        step();
        chk("d_tie1_dma_ack", 32'(dma_ack), 32'd1);
        dma_req = 1'b0;
        step();

        // APB served last, so a new tie goes to DMA unless priority is fixed
        psel = 1'b1; pwrite = 1'b1; paddr = 12'h044;
        step(); penable = 1'b1;
        step(); step();
        psel = 1'b0; penable = 1'b0;
        step();
        psel = 1'b1; penable = 1'b0; pwrite = 1'b0; paddr = 12'h050;
        step();
        penable = 1'b1; dma_req = 1'b1; dma_we = 1'b0; dma_addr = 12'h060;
        step();
        chk("d_tie2_first", 32'(reg_addr), 32'(TIE2_FIRST));
        step();
        chk("d_tie2_pready", 32'(pready), 32'(FIXED));
        chk("d_tie2_dma_ack", 32'(dma_ack), 32'(!FIXED));
        if (pready) begin psel = 1'b0; penable = 1'b0; end
        if (dma_ack) dma_req = 1'b0;
        step(); step();
        chk("d_tie2_second", 32'(reg_addr), 32'(TIE2_SECOND));
        step();
        chk("d_tie2_late_pready", 32'(pready), 32'(!FIXED));
        chk("d_tie2_late_ack", 32'(dma_ack), 32'(FIXED));
        psel = 1'b0; penable = 1'b0; dma_req = 1'b0;
        step();

        // DMA read burst with dma_req held across acks
        dma_req = 1'b1; dma_we = 1'b0; dma_addr = 12'h010;
        for (int k = 0; k < 4; k++) begin
            step(); step();
            chk("d_burst_ack", 32'(dma_ack), 32'd1);
            chk("d_burst_rdata", dma_rdata, 32'hB000_0000 + 32'(k));
            if (k < 3) dma_addr = dma_addr + 12'd4;
            else       dma_req = 1'b0;
            step();
        end

        // Reset during the strobe of a DMA write
        dma_req = 1'b1; dma_we = 1'b1; dma_addr = 12'h070; dma_wdata = 32'h77;
        step();
        chk("d_rst_pre_wen", 32'(reg_write_en), 32'd1);
        preset = 1'b1;
        #1;
        chk("d_rst_wen_drop", 32'(reg_write_en), 32'd0);
        chk("d_rst_reg_addr", 32'(reg_addr), 32'd0);
        chk("d_rst_dma_rdata", dma_rdata, 32'd0);
        dma_req = 1'b0;
        step(); step();
        chk("d_rst_no_ack", 32'(dma_ack), 32'd0);
        preset = 1'b0;
        step();
        dma_req = 1'b1; dma_we = 1'b0; dma_addr = 12'h010;
        step(); step();
        chk("d_post_rst_ack", 32'(dma_ack), 32'd1);
        chk("d_post_rst_rdata", dma_rdata, 32'hB000_0000);
        dma_req = 1'b0;
        step();

        // Random concurrent traffic, checked by the model every cycle
        fork
            begin
                int k;
                for (int i = 0; i < 60; i++) begin
                    repeat ($urandom_range(0, 3)) step();
                    psel = 1'b1; penable = 1'b0; pwrite = 1'($urandom);
                    paddr = AW'($urandom); pwdata = $urandom;
                    step();
                    penable = 1'b1;
                    k = 0;
                    step();
                    while (!pready && k < 20) begin step(); k++; end
                    chk("r_apb_done", 32'(pready), 32'd1);
                    psel = 1'b0; penable = 1'b0;
                end
            end
            begin
                int k;
                for (int i = 0; i < 60; i++) begin
                    if (!dma_req) repeat ($urandom_range(0, 4)) step();
                    dma_req = 1'b1; dma_we = 1'($urandom);
                    dma_addr = AW'($urandom); dma_wdata = $urandom;
                    k = 0;
                    step();
                    while (!dma_ack && k < 20) begin step(); k++; end
                    chk("r_dma_done", 32'(dma_ack), 32'd1);
                    if ($urandom_range(0, 1) == 0 || i == 59) dma_req = 1'b0;
                end
            end
        join

        repeat (5) step();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
